// File: rtl/mem_requester.sv
// CPU-side memory requester: turns one CPU request into one or two memoryModule
// accesses (optional pointer fetch, then the data access), with a per-wait watchdog.
module mem_requester (
    input  logic       clk,
    input  logic       clrN,
    input  logic       reqValid,
    input  logic       reqWrite,
    input  logic       reqIndirect,
    input  logic [7:0] reqAddr,
    input  logic [7:0] reqData,
    output logic       reqBusy,
    output logic       rspValid,
    output logic [7:0] rspData,
    output logic       errTimeout,
    output logic       memStart,
    output logic [1:0] memCntrl,
    output logic [7:0] memAddr,
    output logic [7:0] memDataIn,
    output logic       memIsIndirect,
    input  logic [7:0] memDataOut,
    input  logic       memDataReady
);

    typedef enum logic [2:0] {
        IDLE,
        PTR_REQ,
        PTR_WAIT,
        ACC_REQ,
        ACC_WAIT,
        DONE,
        ERR
    } state_t;

    // The watchdog trips on the WAIT cycle that would bring the count to 255.
    localparam logic [7:0] WDOG_LAST = 8'd254;

    state_t     state_q, state_d;
    logic       write_q, write_d;
    logic       indirect_q, indirect_d;
    logic       errTimeout_q, errTimeout_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] effAddr_q, effAddr_d;
    logic [7:0] wdog_q, wdog_d;
    logic [7:0] rspData_q, rspData_d;

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            indirect_q   <= 1'b0;
            errTimeout_q <= 1'b0;
            addr_q       <= 8'h00;
            data_q       <= 8'h00;
            effAddr_q    <= 8'h00;
            wdog_q       <= 8'h00;
            rspData_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            indirect_q   <= indirect_d;
            errTimeout_q <= errTimeout_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            effAddr_q    <= effAddr_d;
            wdog_q       <= wdog_d;
            rspData_q    <= rspData_d;
        end
    end

    // Bus fields come from state plus captured request, so they stay put from REQ through WAIT.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        indirect_d    = indirect_q;
        errTimeout_d  = errTimeout_q;
        addr_d        = addr_q;
        data_d        = data_q;
        effAddr_d     = effAddr_q;
        wdog_d        = 8'h00;
        rspData_d     = rspData_q;
        rspValid      = 1'b0;
        memStart      = 1'b0;
        memCntrl      = 2'b00;
        memAddr       = 8'h00;
        memDataIn     = 8'h00;
        memIsIndirect = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    write_d      = reqWrite;
                    indirect_d   = reqIndirect;
                    addr_d       = reqAddr;
                    data_d       = reqData;
                    errTimeout_d = 1'b0;
                    state_d      = reqIndirect ? PTR_REQ : ACC_REQ;
                end
            end
            PTR_REQ, PTR_WAIT: begin
                memStart      = (state_q == PTR_REQ);
                memCntrl      = 2'b01;
                memAddr       = addr_q;
                memIsIndirect = 1'b1;
                if (state_q == PTR_REQ) begin
                    state_d = PTR_WAIT;
                end else if (memDataReady) begin
                    effAddr_d = memDataOut;
                    state_d   = ACC_REQ;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_q == WDOG_LAST) begin
                        errTimeout_d = 1'b1;
                        state_d      = ERR;
                    end
                end
            end
            ACC_REQ, ACC_WAIT: begin
                memStart  = (state_q == ACC_REQ);
                memCntrl  = write_q ? 2'b10 : 2'b01;
                memAddr   = indirect_q ? effAddr_q : addr_q;
                memDataIn = write_q ? data_q : 8'h00;
                if (state_q == ACC_REQ) begin
                    state_d = ACC_WAIT;
                end else if (memDataReady) begin
                    if (!write_q) begin
                        rspData_d = memDataOut;
                    end
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_q == WDOG_LAST) begin
                        errTimeout_d = 1'b1;
                        state_d      = ERR;
                    end
                end
            end
            DONE: begin
                rspValid = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign reqBusy    = (state_q != IDLE);
    assign rspData    = rspData_q;
    assign errTimeout = errTimeout_q;

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports (name, direction, width, meaning) in the order REQ-002 to REQ-017.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 clrN  in  1  reset; asynchronous, active-low.
REQ-004 reqValid  in  1  CPU request strobe; sampled only in IDLE.
REQ-005 reqWrite  in  1  request type: 1 = store, 0 = load.
REQ-006 reqIndirect  in  1  request type: 1 = indirect addressing (pointer at reqAddr).
REQ-007 reqAddr  in  8  request address.
REQ-008 reqData  in  8  store data.
REQ-009 reqBusy  out  1  high in every state except IDLE.
REQ-010 rspValid  out  1  one-cycle completion pulse.
REQ-011 rspData  out  8  load result.
REQ-012 errTimeout  out  1  sticky watchdog error flag.
REQ-013 memStart  out  1  one-cycle access strobe to memoryModule.
REQ-014 memCntrl  out  2  access code: 2'b00 idle, 2'b01 read, 2'b10 write; 2'b11 is never driven.
REQ-015 memAddr, memDataIn, memIsIndirect  out  8, 8, 1  access address, write data, and pointer-fetch tag.
REQ-016 memDataOut  in  8  read data returned by memoryModule.
REQ-017 memDataReady  in  1  access-complete indication from memoryModule.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, PTR_REQ, PTR_WAIT, ACC_REQ, ACC_WAIT, DONE and ERR.
REQ-019 In IDLE, reqValid=1 SHALL capture reqWrite, reqIndirect, reqAddr and reqData, clear errTimeout, and transition to PTR_REQ if reqIndirect=1, otherwise to ACC_REQ.
REQ-020 reqValid while reqBusy=1 SHALL be ignored: no capture, no queuing.
REQ-021 PTR_REQ SHALL drive memStart=1, memCntrl=01, memAddr=captured reqAddr and memIsIndirect=1 for one cycle, then go to PTR_WAIT.
REQ-022 In PTR_WAIT, memDataReady=1 SHALL latch memDataOut as the effective address and transition to ACC_REQ.
REQ-023 ACC_REQ SHALL drive memStart=1 for one cycle with memIsIndirect=0 and:
  - memAddr = effective address (indirect) or captured reqAddr (direct);
  - memCntrl = 10 with memDataIn = captured reqData (store), or memCntrl = 01 (load);
  then go to ACC_WAIT.
REQ-024 memCntrl, memAddr, memDataIn and memIsIndirect SHALL be held stable from each *_REQ cycle through the WAIT cycle in which memDataReady is sampled high.
REQ-025 memDataReady SHALL be honoured only in PTR_WAIT and ACC_WAIT, and ignored in every other state, including *_REQ.
REQ-026 In ACC_WAIT, memDataReady=1 SHALL:
  - for a load, latch memDataOut into rspData;
  - for a store, leave rspData unchanged;
  - transition to DONE.
REQ-027 DONE SHALL assert rspValid=1 for exactly one cycle, drive memCntrl=00, and return to IDLE.
REQ-028 Latency: direct access SHALL give rspValid exactly one cycle after memDataReady is sampled; minimum from reqValid is 4 cycles (direct) or 6 cycles (indirect).
REQ-029 Watchdog counter (8-bit):
  - cleared on entry to each WAIT state;
  - increments every WAIT cycle without memDataReady;
  - on reaching 255, the FSM SHALL go to ERR instead of waiting further.
REQ-030 ERR SHALL set errTimeout=1, drive memCntrl=00, assert no rspValid, and return to IDLE next cycle.
REQ-031 errTimeout SHALL remain 1 until reset or the next accepted request.
REQ-032 memDataReady arriving in the same cycle the counter reaches 255 SHALL win: normal completion, no error.
REQ-033 memStart SHALL never be high in two consecutive cycles.

Reset
REQ-034 While clrN=0, regardless of clock, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the watchdog, effective address and captured fields SHALL be 0.
REQ-035 clrN asserted mid-transaction SHALL abandon the transaction immediately, with no rspValid and no memStart afterwards.
REQ-036 After clrN deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-037 Direct load: reqAddr=0x3C, memDataReady on the 2nd ACC_WAIT cycle with memDataOut=0xA5 -> one memStart with memCntrl=01, memAddr=0x3C; rspData=0xA5 with one rspValid pulse.
REQ-038 Direct store: reqAddr=0x10, reqData=0x7E -> memCntrl=10, memAddr=0x10, memDataIn=0x7E held until memDataReady; rspValid pulses; rspData unchanged.
REQ-039 Indirect load: reqAddr=0x05, pointer read returns 0x80, then data 0x11 -> first memStart with memAddr=0x05, memIsIndirect=1; second with memAddr=0x80, memIsIndirect=0; rspData=0x11.
REQ-040 Timeout: memDataReady never asserted -> ERR after 255 WAIT cycles, errTimeout=1, no rspValid; the next reqValid clears errTimeout.
REQ-041 Reset mid-ACC_WAIT and busy-ignore:
  - clrN=0 -> all outputs 0 asynchronously;
  - reqValid pulsed during ACC_WAIT of a prior request -> that request is never issued.
